gg_emulation_remove: RTL and testbench
======================================

# gg_emulation_remove

Removes H.264/AVC emulation-prevention bytes from a 128-bit wide, big-endian NAL byte stream. Every 0x03 that follows two consecutive 0x00 bytes is deleted, the surviving bytes are re-packed into full 16-byte output words, and a per-byte flag marks the byte that followed each deleted 0x03. The block sits between the bitstream input buffer and the downstream syntax parser.

## Interface
- No parameters.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- iport  in  128  input word; byte 0 (first in stream) = iport[127:120], byte 15 = iport[7:0].
- iport_valid  in  1  iport holds a valid word.
- iport_ready  out  1  block can accept a word this cycle.
- oport  out  128  output word with 0x03 bytes removed, same byte order as iport.
- flag  out  16  flag[15-i] = 1 means oport byte i directly followed a removed 0x03.
- oport_ready  in  1  downstream accepts oport this cycle.
- oport_valid  out  1  oport/flag hold a valid word.

## Operation
- Input is accepted on a rising edge when iport_valid && iport_ready. Bytes are processed strictly in stream order, byte 0 to byte 15, then continuing into the next accepted word.
- Per-byte state carried across words:
  - zcnt: 0..2, the saturating count of preceding 0x00 bytes.
  - pend: the next kept byte gets its flag set.
- Per-byte rule:
  - If zcnt==2 and the byte is 0x03, drop the byte, set zcnt=0 and pend=1.
  - Otherwise keep the byte and give it flag=pend, then clear pend. Set zcnt = min(zcnt+1, 2) if the byte is 0x00, else zcnt=0.
- Consequences:
  - 00 00 00 03: the 0x03 is dropped.
  - 00 00 03 03: the first 0x03 is dropped and the second is kept and flagged.
  - 00 00 03 00 00 03: both 0x03 are dropped.
  - The pattern is detected across word boundaries, e.g. bytes 14..15 = 00 00 with the next word's byte 0 = 03.
- Kept bytes with their flags are appended to a residual buffer of at most 31 bytes. When the buffer holds 16 or more bytes, the oldest 16 form the output word.
- At most 16 bytes enter per cycle, so at most one word completes per accepted input.
- Partial words (fewer than 16 kept bytes) are never emitted. They wait for further input and are discarded on reset.
- Backpressure: while oport_valid && !oport_ready, oport, flag and all internal state hold. iport_ready = !oport_valid || oport_ready.

## Timing
- Latency is 1 edge. A word completed by the input accepted at edge N drives oport, flag and oport_valid=1 from just after edge N.
- oport_valid drops after the next edge at which the word is consumed (oport_ready=1) and no new word completes.
- With oport_ready=1 continuously, the block sustains one input word per cycle. Output words are less than or equal in number to input words.
- When reset=0 at a rising edge, the following are cleared: oport_valid=0, oport=0, flag=0, residual count=0, zcnt=0, pend=0. While reset is low, iport_ready=0.
- Reset mid-stream drops all buffered bytes and carried state. The next accepted word starts a fresh stream with no zero history.
- An idle cycle (iport_valid=0) changes no state. Zero history carries over across idle gaps.

## Test plan
- Reset, then 10 words of 128'h06 -> 10 output words of 128'h06, flag=0000, each valid one edge after its input.
- Words 04_00_00_00_00_03_00_00_00_00_00_00_00_00_00_00 then 05_00_00_03_00_00_03_00.. (stream aligned) -> first output 04_00_00_00_00_00_00_00_00_00_00_00_00_00_00_05 with flag=0400.
- Word ending ..00_00 followed by a word starting 03_11.. -> the 0x03 is dropped and 0x11 is output with its flag bit set.
- Sequences 00_00_03_03 and 00_03_00_00_03_00_00_03 -> second 0x03 of the first sequence kept and flagged; all 0x03 following two zeros dropped. Check against a byte-serial reference model over 22 random words (bytes biased toward 0x00/0x03) across 10 seeds.
- oport_ready=0 for 3 cycles with a word pending -> oport, flag and valid held; iport_ready=0; no data lost or duplicated after release.
- Assert reset low mid-stream with residual bytes buffered -> oport_valid=0 next cycle, and post-reset output matches a fresh stream.

Source files
------------

// File: rtl/gg_emulation_remove.sv
// H.264 emulation-prevention byte removal on a 128-bit big-endian byte stream.
// Dropped 0x03 bytes are squeezed out and survivors are re-packed into full 16-byte words.

module gg_er_lane (
  input  logic [7:0] byte_in,
  input  logic [1:0] zcnt_in,
  input  logic       pend_in,
  output logic       keep,
  output logic       flg,
  output logic [1:0] zcnt_out,
  output logic       pend_out
);
  logic drop;

  assign drop     = (zcnt_in == 2'd2) && (byte_in == 8'h03);
  assign keep     = !drop;
  assign flg      = keep && pend_in;
  assign pend_out = drop;

  always_comb begin
    zcnt_out = 2'd0;
    if (!drop && byte_in == 8'h00)
      zcnt_out = (zcnt_in == 2'd2) ? 2'd2 : zcnt_in + 2'd1;
  end
endmodule

module gg_emulation_remove (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] iport,
  input  logic         iport_valid,
  output logic         iport_ready,
  output logic [127:0] oport,
  output logic [15:0]  flag,
  input  logic         oport_ready,
  output logic         oport_valid
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;
  localparam int BUF_N     = 2 * NUM_LANES;

  logic [NUM_LANES:0][1:0]        zc;
  logic [NUM_LANES:0]             pd;
  logic [NUM_LANES-1:0]           keep, kflg;
  logic [NUM_LANES-1:0][4:0]      slot;
  logic [4:0]                     nkeep, total, cnt_q, cnt_d;
  logic [1:0]                     zcnt_q;
  logic                           pend_q;
  logic [BUF_N-1:0][VEC_W-1:0]    rdat_q, rdat_cat, rdat_d;
  logic [BUF_N-1:0]               rflg_q, rflg_cat, rflg_d;
  logic [127:0]                   oport_d;
  logic [15:0]                    flag_d;
  logic                           accept, emit;

  assign iport_ready = reset && (!oport_valid || oport_ready);
  assign accept      = iport_valid && iport_ready;
  assign zc[0]       = zcnt_q;
  assign pd[0]       = pend_q;

  // Zero-run state ripples through the 16 lanes in stream order.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    gg_er_lane u_lane (
      .byte_in  (iport[(NUM_LANES-1-g)*VEC_W +: VEC_W]),
      .zcnt_in  (zc[g]),
      .pend_in  (pd[g]),
      .keep     (keep[g]),
      .flg      (kflg[g]),
      .zcnt_out (zc[g+1]),
      .pend_out (pd[g+1])
    );
  end

  // Destination slot of each kept byte = number of kept bytes ahead of it.
  always_comb begin
    nkeep = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      slot[j] = nkeep;
      nkeep   = nkeep + {4'd0, keep[j]};
    end
  end

  // Residual buffer: index 0 is the oldest byte; new bytes land after cnt_q.
  always_comb begin
    rdat_cat = rdat_q;
    rflg_cat = rflg_q;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (keep[j]) begin
        rdat_cat[cnt_q + slot[j]] = iport[(NUM_LANES-1-j)*VEC_W +: VEC_W];
        rflg_cat[cnt_q + slot[j]] = kflg[j];
      end
    end
    total = cnt_q + nkeep;
    emit  = accept && (total >= 5'd16);
    for (int i = 0; i < NUM_LANES; i++) begin
      oport_d[(NUM_LANES-1-i)*VEC_W +: VEC_W] = rdat_cat[i];
      flag_d[NUM_LANES-1-i]                  = rflg_cat[i];
    end
    if (emit) begin
      rdat_d = rdat_cat >> (NUM_LANES*VEC_W);
      rflg_d = rflg_cat >> NUM_LANES;
      cnt_d  = total - 5'd16;
    end else begin
      rdat_d = rdat_cat;
      rflg_d = rflg_cat;
      cnt_d  = total;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdat_q      <= '0;
      rflg_q      <= '0;
      cnt_q       <= '0;
      zcnt_q      <= '0;
      pend_q      <= 1'b0;
      oport       <= '0;
      flag        <= '0;
      oport_valid <= 1'b0;
    end else begin
      if (accept) begin
        rdat_q <= rdat_d;
        rflg_q <= rflg_d;
        cnt_q  <= cnt_d;
        zcnt_q <= zc[NUM_LANES];
        pend_q <= pd[NUM_LANES];
      end
      if (emit) begin
        oport       <= oport_d;
        flag        <= flag_d;
        oport_valid <= 1'b1;
      end else if (oport_ready) begin
        oport_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gg_emulation_remove.sv
// Scoreboard bench for gg_emulation_remove: a byte-serial queue model predicts
// every output word; a negedge monitor compares whatever the DUT presents.
module tb_gg_emulation_remove;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] iport = '0;
  logic         iport_valid = 1'b0;
  logic         iport_ready;
  logic [127:0] oport;
  logic [15:0]  flag;
  logic         oport_ready = 1'b1;
  logic         oport_valid;

  always #5 clk = ~clk;

  gg_emulation_remove dut (
    .clk(clk), .reset(reset),
    .iport(iport), .iport_valid(iport_valid), .iport_ready(iport_ready),
    .oport(oport), .flag(flag),
    .oport_ready(oport_ready), .oport_valid(oport_valid)
  );

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  int rdy_mode = 0;

  logic [7:0]   rq[$];
  bit           rf[$];
  int           mz = 0;
  bit           mp = 1'b0;
  logic [127:0] exp_w[$];
  logic [15:0]  exp_f[$];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  // Stream rule applied one byte at a time; whole words leave a byte FIFO.
  function automatic void model_word(logic [127:0] w);
    logic [7:0]   b;
    logic [127:0] ow;
    logic [15:0]  of;
    for (int i = 0; i < 16; i++) begin
      b = w[127-8*i -: 8];
      if (mz == 2 && b == 8'h03) begin
        mz = 0;
        mp = 1'b1;
      end else begin
        rq.push_back(b);
        rf.push_back(mp);
        mp = 1'b0;
        mz = (b == 8'h00) ? ((mz < 2) ? mz + 1 : 2) : 0;
      end
    end
    if (rq.size() >= 16) begin
      for (int i = 0; i < 16; i++) begin
        ow[127-8*i -: 8] = rq.pop_front();
        of[15-i]         = rf.pop_front();
      end
      exp_w.push_back(ow);
      exp_f.push_back(of);
    end
  endfunction

  always @(negedge clk) begin
    bit mv;
    bit er;
    if (mon_en) begin
      mv = (exp_w.size() != 0);
      er = reset && (!mv || oport_ready);
      chk("oport_valid", 128'(oport_valid), 128'(mv));
      chk("iport_ready", 128'(iport_ready), 128'(er));
      if (mv && oport_valid) begin
        chk("oport", oport, exp_w[0]);
        chk("flag", 128'(flag), 128'(exp_f[0]));
      end
      if (!reset) begin
        rq.delete(); rf.delete(); exp_w.delete(); exp_f.delete();
        mz = 0;
        mp = 1'b0;
      end else begin
        if (mv && oport_ready) begin
          void'(exp_w.pop_front());
          void'(exp_f.pop_front());
        end
        if (iport_valid && er) model_word(iport);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       oport_ready = 1'b1;
        1:       oport_ready = ($urandom_range(0, 3) != 0);
        default: oport_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [127:0] w);
    bit acc;
    acc = 1'b0;
    iport = w;
    iport_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      acc = iport_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    iport_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_timeout: got not-accepted want accepted for %h", w);
    end
  endtask

  task automatic idle(input int n);
    iport_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    iport_valid = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 128'(oport_valid), 128'(0));
    chk("rst_oport", oport, 128'(0));
    chk("rst_flag", 128'(flag), 128'(0));
    chk("rst_iready", 128'(iport_ready), 128'(0));
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic expect_out(input string nm, input logic [127:0] w, input logic [15:0] f);
    @(negedge clk);
    chk({nm, "_valid"}, 128'(oport_valid), 128'(1));
    chk(nm, oport, w);
    chk({nm, "_flag"}, 128'(flag), 128'(f));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] w;

    do_reset();
    for (int k = 0; k < 10; k++) begin
      send({16{8'h06}});
      expect_out("w06", {16{8'h06}}, 16'h0000);
    end

    do_reset();
    send(128'h04_00_00_00_00_03_00_00_00_00_00_00_00_00_00_00);
    send(128'h05_00_00_03_00_00_03_00_00_00_00_00_00_00_00_00);
    expect_out("pair", 128'h04_00_00_00_00_00_00_00_00_00_00_00_00_00_00_05, 16'h0400);

    do_reset();
    send(128'h1111_1111_1111_1111_1111_1111_1111_0000);
    expect_out("xb_first", 128'h1111_1111_1111_1111_1111_1111_1111_0000, 16'h0000);
    send(128'h0311_1111_1111_1111_1111_1111_1111_1111);
    send({16{8'h22}});
    expect_out("xb_flag", 128'h1111_1111_1111_1111_1111_1111_1111_1122, 16'h8000);

    do_reset();
    send(128'h0000_0303_4444_4444_4444_4444_4444_4444);
    send({16{8'h55}});
    expect_out("dbl03", 128'h0000_0344_4444_4444_4444_4444_4444_4455, 16'h2000);
    send(128'h0003_0000_0300_0003_6666_6666_6666_6666);
    send({16{8'h00}});
    send(128'h0300_0003_0303_0000_0003_0000_0000_0003);
    idle(3);

    // Hold the first word for three cycles while the next word waits.
    do_reset();
    rdy_mode = 2;
    oport_ready = 1'b0;
    send({16{8'h77}});
    iport = {16{8'h12}};
    iport_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 128'(oport_valid), 128'(1));
      chk("bp_oport", oport, {16{8'h77}});
      chk("bp_flag", 128'(flag), 128'(0));
      chk("bp_iready", 128'(iport_ready), 128'(0));
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    oport_ready = 1'b1;
    send({16{8'h12}});
    expect_out("bp_next", {16{8'h12}}, 16'h0000);

    // Reset with 15 bytes buffered and two zeros of history.
    do_reset();
    send(128'h0000_0388_8888_8888_8888_8888_8888_0000);
    do_reset();
    send(128'h0399_9999_9999_9999_9999_9999_9999_9999);
    expect_out("post_rst", 128'h0399_9999_9999_9999_9999_9999_9999_9999, 16'h0000);

    for (int s = 0; s < 10; s++) begin
      do_reset();
      void'($urandom(s * 7 + 3));
      rdy_mode = s % 2;
      if (rdy_mode == 0) oport_ready = 1'b1;
      for (int k = 0; k < 22; k++) begin
        for (int i = 0; i < 16; i++) begin
          case ($urandom_range(0, 3))
            0, 2:    w[127-8*i -: 8] = 8'h00;
            1:       w[127-8*i -: 8] = 8'h03;
            default: w[127-8*i -: 8] = 8'($urandom_range(0, 255));
          endcase
        end
        send(w);
        if ($urandom_range(0, 4) == 0) idle(1);
      end
      rdy_mode = 0;
      oport_ready = 1'b1;
      idle(4);
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
